// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer (rst_seq) and its
// reset synchronizer.
package rst_seq_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Smallest counter width able to hold max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 32'd0) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES
// rising edges of clk_i.
module rst_sync
  import rst_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift a constant one through the chain once reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged multi-channel reset sequencer with an optional run-cycle budget,
// enabled by defining RST_SEQ_RUN_LIMIT_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned STAGGER_CYC = 4,
  parameter int unsigned CNT_W       = 24
) (
  input  logic              sysclk,
  input  logic              cpu_resetn,
  input  logic              soft_rst_req,
  input  logic [CNT_W-1:0]  run_limit,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              all_released,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              run_done
);

  localparam int unsigned REL_SPAN = (NUM_CH - 32'd1) * STAGGER_CYC;
  localparam int unsigned HW       = cnt_width(HOLD_CYC - 32'd1);
  localparam int unsigned SW       = cnt_width(REL_SPAN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 32'd1);
  localparam logic [SW-1:0] REL_LAST  = SW'(REL_SPAN);

  logic              sync_rst_n_s;
  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [SW-1:0]     stag_q, stag_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              all_q, all_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
`ifdef RST_SEQ_RUN_LIMIT_EN
  logic [CNT_W-1:0]  limit_q, limit_d;
`else
  logic              unused_run_limit_s;
  assign unused_run_limit_s = ^run_limit;
`endif

  rst_sync u_rst_sync (
    .clk_i  (sysclk),
    .rst_ni (cpu_resetn),
    .rst_no (sync_rst_n_s)
  );

  // Channels whose release offset has been reached at stagger count s.
  function automatic logic [NUM_CH-1:0] rel_mask(input logic [SW-1:0] s);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m[i] = (32'(s) >= (32'(i) * STAGGER_CYC));
    end
    return m;
  endfunction

  // Sequencer next-state and output computation.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
`ifdef RST_SEQ_RUN_LIMIT_EN
    limit_d = limit_q;
`endif
    if (soft_rst_req && (state_q != ST_ASSERT)) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      stag_d  = '0;
      ch_d    = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (sync_rst_n_s) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            state_d = ST_ASSERT;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            stag_d = '0;
            ch_d   = rel_mask('0);
            // A single channel is fully released on RELEASE entry itself.
            if (NUM_CH == 32'd1) begin
              state_d = ST_RUN;
              cnt_d   = '0;
`ifdef RST_SEQ_RUN_LIMIT_EN
              limit_d = run_limit;
`endif
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RELEASE: begin
          stag_d = stag_q + SW'(1);
          ch_d   = ch_q | rel_mask(stag_d);
          if (stag_d == REL_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
`ifdef RST_SEQ_RUN_LIMIT_EN
            limit_d = run_limit;
`endif
          end else begin
            state_d = ST_RELEASE;
          end
        end
        ST_RUN: begin
`ifdef RST_SEQ_RUN_LIMIT_EN
          if ((limit_q != '0) && (cnt_q == (limit_q - CNT_W'(1)))) begin
            state_d = ST_DONE;
            cnt_d   = limit_q;
            done_d  = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
`else
          state_d = ST_RUN;
`endif
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
    all_d = &ch_d;
  end

  // State and output registers; cpu_resetn clears everything without a clock.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      stag_q  <= '0;
      ch_q    <= '0;
      all_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_RUN_LIMIT_EN
      limit_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      ch_q    <= ch_d;
      all_q   <= all_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef RST_SEQ_RUN_LIMIT_EN
      limit_q <= limit_d;
`endif
    end
  end

  assign ch_rst_n     = ch_q;
  assign all_released = all_q;
  assign run_cnt      = cnt_q;
  assign run_done     = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Randomized scoreboard bench for rst_seq: a time-since-sequence-start model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_rst_seq;

  localparam int NCH   = 3;
  localparam int HOLD  = 6;
  localparam int STG   = 3;
  localparam int CW    = 6;
  localparam int REL_T = HOLD + (NCH - 1) * STG;
  localparam int CMAX  = (1 << CW) - 1;

  logic            sysclk;
  logic            cpu_resetn;
  logic            soft_rst_req;
  logic [CW-1:0]   run_limit;
  logic [NCH-1:0]  ch_rst_n;
  logic            all_released;
  logic [CW-1:0]   run_cnt;
  logic            run_done;
  bit              clk_en = 1'b1;

  typedef struct packed {
    logic [NCH-1:0] ch;
    logic           all;
    logic [CW-1:0]  cnt;
    logic           done;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: edges seen since release, and cycles since HOLD entry.
  int   pre_cnt = 0;
  bit   started = 1'b0;
  int   t       = 0;
  int   lim     = 0;

  rst_seq #(
    .NUM_CH(NCH), .HOLD_CYC(HOLD), .STAGGER_CYC(STG), .CNT_W(CW)
  ) dut (
    .sysclk       (sysclk),
    .cpu_resetn   (cpu_resetn),
    .soft_rst_req (soft_rst_req),
    .run_limit    (run_limit),
    .ch_rst_n     (ch_rst_n),
    .all_released (all_released),
    .run_cnt      (run_cnt),
    .run_done     (run_done)
  );

  initial begin
    sysclk = 1'b0;
    forever begin
      #5;
      if (clk_en) sysclk = ~sysclk;
    end
  end

  function automatic obs_t expect_now();
    obs_t e;
    int   k;
    e = '0;
    if (started) begin
      for (int i = 0; i < NCH; i++) e.ch[i] = (t >= HOLD + i * STG);
      e.all = (t >= REL_T);
`ifdef RST_SEQ_RUN_LIMIT_EN
      if (t >= REL_T) begin
        k = t - REL_T;
        if (lim != 0) begin
          e.cnt  = CW'((k < lim) ? k : lim);
          e.done = (k >= lim);
        end else begin
          e.cnt = CW'((k < CMAX) ? k : CMAX);
        end
      end
`endif
    end
    return e;
  endfunction

  // Model: advance on every rising edge using the inputs held across it.
  always @(posedge sysclk) begin
    if (!cpu_resetn) begin
      started = 1'b0;
      pre_cnt = 0;
      t       = 0;
    end else if (!started) begin
      pre_cnt++;
      if (pre_cnt == 3) begin
        started = 1'b1;
        t       = 0;
      end
    end else if (soft_rst_req) begin
      t = 0;
    end else if (t < 1000000) begin
      t++;
    end
    if (started && t == REL_T) lim = int'(run_limit);
    exp_q.push_back(expect_now());
  end

  // Monitor: compare one expected observation per falling edge.
  always @(negedge sysclk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ch_rst_n, all_released, run_cnt, run_done};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL obs @%0t: got ch=%b all=%b cnt=%0d done=%b, expected ch=%b all=%b cnt=%0d done=%b",
                 $time, a.ch, a.all, a.cnt, a.done, e.ch, e.all, e.cnt, e.done);
      end
    end
  end

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({ch_rst_n, all_released, run_cnt, run_done} !== '0) begin
      failures++;
      $display("FAIL %s: got ch=%b all=%b cnt=%0d done=%b, expected all zero",
               name, ch_rst_n, all_released, run_cnt, run_done);
    end
  endtask

  task automatic rand_cycle(input int p_soft);
    step();
    soft_rst_req = ($urandom_range(0, 99) < p_soft);
    run_limit    = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, CMAX));
  endtask

  task automatic async_abort();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      step();
      soft_rst_req = 1'b0;
      if (started && t >= HOLD && t < REL_T) found = 1'b1;
      else if (started && t >= REL_T) soft_rst_req = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL async_wait: got no RELEASE phase within 80 cycles, expected one");
    end else begin
      clk_en = 1'b0;
      #2 cpu_resetn = 1'b0;
      #1 check_zero("async_abort_immediate");
      #6 check_zero("async_abort_hold");
      clk_en = 1'b1;
      repeat (2) step();
      cpu_resetn = 1'b1;
    end
  endtask

  initial begin
    int mode;
    int len;
    cpu_resetn   = 1'b0;
    soft_rst_req = 1'b0;
    run_limit    = '0;
    #2 check_zero("reset_state");
    repeat (3) step();
    cpu_resetn = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0, 1: begin
          len = $urandom_range(20, 110);
          for (int c = 0; c < len; c++) rand_cycle(0);
        end
        2: begin
          len = $urandom_range(20, 60);
          for (int c = 0; c < len; c++) rand_cycle(4);
        end
        3: begin
          len = $urandom_range(2, 8);
          for (int c = 0; c < len; c++) rand_cycle(100);
          rand_cycle(0);
        end
        default: async_abort();
      endcase
    end
    // Directed tail: unlimited run to saturation, then a small budget.
    step();
    soft_rst_req = 1'b1;
    run_limit    = '0;
    step();
    soft_rst_req = 1'b0;
    repeat (100) step();
    soft_rst_req = 1'b1;
    run_limit    = CW'(5);
    step();
    soft_rst_req = 1'b0;
    repeat (40) step();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent reset channels (1..8).
REQ-002 Parameter HOLD_CYC, default 16: cycles all channels stay asserted after synchronized reset release (>=1).
REQ-003 Parameter STAGGER_CYC, default 4: cycles between release of consecutive channels (>=1).
REQ-004 Parameter CNT_W, default 24: width of the run counter and run_limit.
REQ-005 sysclk  in  1  sole clock; all logic rising-edge.
REQ-006 cpu_resetn  in  1  reset; asynchronous, active-low.
REQ-007 soft_rst_req  in  1  synchronous request to re-run the reset sequence; pulse or level.
REQ-008 run_limit  in  CNT_W  run-cycle budget; 0 = unlimited; sampled on entry to RUN.
REQ-009 ch_rst_n  out  NUM_CH  per-channel active-low reset; bit 0 released first.
REQ-010 all_released  out  1  high while every ch_rst_n bit is 1.
REQ-011 run_cnt  out  CNT_W  cycles spent in RUN since last sequence.
REQ-012 run_done  out  1  sticky; high once run budget is exhausted.

Function
REQ-013 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN, DONE.
REQ-014 ASSERT -> HOLD on the first cycle the internal synchronized reset is deasserted.
REQ-015 HOLD SHALL count HOLD_CYC cycles, then enter RELEASE with stagger counter 0.
REQ-016 In RELEASE, channel i SHALL deassert (go 1) exactly i*STAGGER_CYC cycles after RELEASE entry; once released a channel stays released until the next sequence.
REQ-017 RELEASE -> RUN in the cycle the last channel (NUM_CH-1) is released; all_released rises that cycle.
REQ-018 Entry to RUN SHALL latch run_limit and clear run_cnt to 0; run_cnt increments by 1 each RUN cycle.
REQ-019 With latched limit L != 0, when run_cnt == L-1 the FSM SHALL enter DONE next cycle with run_cnt == L and run_done = 1.
REQ-020 With L == 0 the FSM SHALL stay in RUN; run_cnt saturates at all-ones, never wraps.
REQ-021 DONE SHALL hold run_cnt, keep channels released, keep run_done = 1.
REQ-022 soft_rst_req = 1 in HOLD, RELEASE, RUN or DONE SHALL next cycle assert all channels, clear run_cnt and run_done, and enter HOLD; a held request keeps the FSM in HOLD with its counter at 0.
REQ-023 soft_rst_req in ASSERT is ignored.
REQ-024 Changes of run_limit outside RUN entry SHALL have no effect.

Reset
REQ-025 cpu_resetn low SHALL immediately (asynchronously) force ch_rst_n = 0, all_released = 0, run_cnt = 0, run_done = 0, state = ASSERT.
REQ-026 Deassertion of cpu_resetn SHALL pass through a 2-flop synchronizer; internal release occurs on the 2nd rising edge after cpu_resetn rises.
REQ-027 cpu_resetn low mid-sequence (any state) SHALL abort it with the REQ-025 values; no partial release persists.

Configuration
REQ-028 Macro RST_SEQ_RUN_LIMIT_EN: defined -> run counter, run_limit, run_done behave per REQ-018..021.
REQ-029 Undefined -> run_limit ignored, run_cnt and run_done tied to 0, FSM stays in RUN indefinitely, DONE unreachable; ports remain present.

Structure
REQ-030 Shared package rst_seq_pkg SHALL hold the state enum and the synchronizer depth constant (2).
REQ-031 Sub-module rst_sync (2-flop async-assert / sync-deassert synchronizer) SHALL be instantiated once for cpu_resetn.

Verification
REQ-032 NUM_CH=2, HOLD=16, STAGGER=4: release cpu_resetn at edge 0 -> ch_rst_n[0] rises edge 2+16+1, ch_rst_n[1] 4 cycles later, all_released with it.
REQ-033 run_limit=10000 -> run_done rises exactly 10000 cycles after all_released, run_cnt=10000 held.
REQ-034 run_limit=0, CNT_W=4 -> run_cnt saturates at 15, run_done stays 0.
REQ-035 soft_rst_req 1-cycle pulse in RUN at run_cnt=50 -> next cycle ch_rst_n=0, run_cnt=0; full sequence repeats.
REQ-036 cpu_resetn low during RELEASE after channel 0 released -> outputs 0 immediately, no clock needed.
REQ-037 Macro undefined, run_limit=5 -> run_done never rises, run_cnt stays 0 for 100 cycles.
